// File: rtl/cos_fxp_pkg.sv
// -----------------------------------------------------------------------------
// cos_fxp_pkg
//   Shared fixed-point definitions for the cosine datapath. The range reducer,
//   the cosine core and their benches all import this package.
//
//   Contents:
//     FRAC                   fraction bits, Q.23, for input and output angles
//     PI_2, PI, TWO_PI       angle constants in Q.23
//     TWO_PI_X8              8*TWO_PI, the coarse step used when
//                            COARSE_REDUCE_EN is defined
//     state_e                range-reducer FSM states
//     q1_23_t                24-bit unsigned Q1.23 angle word
// -----------------------------------------------------------------------------
package cos_fxp_pkg;

    localparam int FRAC = 23;

    localparam int unsigned PI_2      = 32'd13176795;
    localparam int unsigned PI        = 32'd26353589;
    localparam int unsigned TWO_PI    = 32'd52707179;
    localparam int unsigned TWO_PI_X8 = 32'd421657432;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WRAP = 2'd1,
        FOLD = 2'd2
    } state_e;

    typedef logic [FRAC:0] q1_23_t;

endpackage

// File: rtl/cos_quadrant_fold.sv
// -----------------------------------------------------------------------------
// cos_quadrant_fold
//   Purely combinational quadrant fold. Takes a remainder r in [0, TWO_PI)
//   and maps it to an angle in [0, PI_2] plus a negate flag, such that
//   cos(r) = (negate_out ? -1 : 1) * cos(angle_out).
//
//   Parameters:
//     WI          input angle width of the reducer; r_in is WI-1 bits
//     W           output angle width (Q1.23)
//
//   Ports:
//     r_in        input  [WI-2:0]  remainder, already wrapped below TWO_PI
//     angle_out   output [W-1:0]   folded angle, Q1.23, in [0, PI_2]
//     negate_out  output           1 when the cosine result must be negated
// -----------------------------------------------------------------------------
module cos_quadrant_fold
    import cos_fxp_pkg::*;
#(
    parameter int WI = 32,
    parameter int W  = 24
) (
    input  logic [WI-2:0] r_in,
    output logic [W-1:0]  angle_out,
    output logic          negate_out
);

    logic [WI-1:0] r_ext;
    logic [WI-1:0] r1;

    always_comb begin
        r_ext      = {1'b0, r_in};
        r1         = r_ext;
        angle_out  = '0;
        negate_out = 1'b0;

        // Upper half-turn: cos(2pi - x) = cos(x).
        if (r_ext >= WI'(PI)) begin
            r1 = WI'(TWO_PI) - r_ext;
        end

        // Second quadrant: cos(x) = -cos(pi - x). The Q.23 constants are
        // rounded so that TWO_PI - PI is PI + 1; r == PI therefore lands one
        // LSB past PI, and the subtraction is clamped to 0 (cos(pi) = -1).
        if (r1 > WI'(PI_2)) begin
            negate_out = 1'b1;
            if (r1 >= WI'(PI)) begin
                angle_out = '0;
            end else begin
                angle_out = W'(WI'(PI) - r1);
            end
        end else begin
            angle_out = W'(r1);
        end
    end

endmodule

// File: rtl/cos_range_reducer.sv
// -----------------------------------------------------------------------------
// cos_range_reducer
//   Argument-reduction stage in front of the TaylorSeries cosine core. Maps a
//   signed Q8.23 angle in radians to [0, PI_2] in Q1.23 plus a result-negate
//   flag. angle_out / ready_out feed the core's angle_in / start directly.
//
//   Operation: IDLE captures |angle_in| on start, WRAP subtracts TWO_PI once
//   per cycle until the remainder is below TWO_PI, FOLD registers the quadrant
//   fold and pulses ready_out for one cycle.
//
//   Optional build macro:
//     COARSE_REDUCE_EN  WRAP first removes 8*TWO_PI per cycle while possible,
//                       cutting worst-case latency; results are identical.
//
//   Parameters:
//     WI          input angle width, signed Q8.23
//     W           output angle width, unsigned Q1.23
//
//   Ports:
//     clock       input           system clock, rising edge
//     reset       input           asynchronous active-low reset
//     start       input           one-cycle request pulse, sampled in IDLE only
//     angle_in    input  [WI-1:0] signed angle, Q8.23 radians
//     busy        output          high while an accepted request is in flight
//     ready_out   output          one-cycle completion pulse
//     angle_out   output [W-1:0]  reduced angle, held until next completion
//     negate_out  output          1 when cos(angle_in) = -cos(angle_out)
// -----------------------------------------------------------------------------
module cos_range_reducer
    import cos_fxp_pkg::*;
#(
    parameter int WI = 32,
    parameter int W  = 24
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [WI-1:0] angle_in,
    output logic          busy,
    output logic          ready_out,
    output logic [W-1:0]  angle_out,
    output logic          negate_out
);

    localparam logic [WI-2:0] TWO_PI_R = (WI-1)'(TWO_PI);
`ifdef COARSE_REDUCE_EN
    localparam logic [WI-2:0] TWO_PI_X8_R = (WI-1)'(TWO_PI_X8);
`endif

    state_e        state_q, state_d;
    logic [WI-2:0] r_q, r_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic [W-1:0]  angle_q, angle_d;
    logic          negate_q, negate_d;

    logic [WI-2:0] abs_in;
    logic [W-1:0]  fold_angle;
    logic          fold_negate;

    // |angle_in| in WI-1 bits. -2^(WI-1) has no positive counterpart and
    // saturates to the largest representable magnitude.
    always_comb begin
        if (!angle_in[WI-1]) begin
            abs_in = angle_in[WI-2:0];
        end else if (angle_in == {1'b1, {(WI-1){1'b0}}}) begin
            abs_in = '1;
        end else begin
            abs_in = (WI-1)'(-angle_in);
        end
    end

    cos_quadrant_fold #(
        .WI (WI),
        .W  (W)
    ) u_fold (
        .r_in       (r_q),
        .angle_out  (fold_angle),
        .negate_out (fold_negate)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            r_q      <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            angle_q  <= '0;
            negate_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            angle_q  <= angle_d;
            negate_q <= negate_d;
        end
    end

    // Next-state logic. The coarse step is always larger than TWO_PI, so
    // r < TWO_PI alone decides when wrapping is finished.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = WRAP;
            WRAP: if (r_q < TWO_PI_R) state_d = FOLD;
            FOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output register updates.
    always_comb begin
        r_d      = r_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        angle_d  = angle_q;
        negate_d = negate_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d    = abs_in;
                    busy_d = 1'b1;
                end
            end
            WRAP: begin
`ifdef COARSE_REDUCE_EN
                if (r_q >= TWO_PI_X8_R) begin
                    r_d = r_q - TWO_PI_X8_R;
                end else if (r_q >= TWO_PI_R) begin
                    r_d = r_q - TWO_PI_R;
                end
`else
                if (r_q >= TWO_PI_R) begin
                    r_d = r_q - TWO_PI_R;
                end
`endif
            end
            FOLD: begin
                angle_d  = fold_angle;
                negate_d = fold_negate;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign ready_out  = ready_q;
    assign angle_out  = angle_q;
    assign negate_out = negate_q;

endmodule

// File: tb/tb_cos_range_reducer.sv
// -----------------------------------------------------------------------------
// tb_cos_range_reducer
//   Randomized and directed bench for cos_range_reducer. A behavioural model
//   computes the reduced angle with modulo arithmetic and the completion edge
//   from the subtraction count; a compare process checks every output on every
//   falling edge. Directed transactions pin the model with literal results.
//   Define COARSE_REDUCE_EN for both RTL and bench to test the coarse build.
// -----------------------------------------------------------------------------
module tb_cos_range_reducer;

    localparam int WI = 32;
    localparam int W  = 24;

    localparam longint PI_2_M   = 13176795;
    localparam longint PI_M     = 26353589;
    localparam longint TWO_PI_M = 52707179;
    localparam longint X8_M     = 421657432;

`ifdef COARSE_REDUCE_EN
    localparam int LAT_MAX = 7;
`else
    localparam int LAT_MAX = 42;
`endif

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [WI-1:0] angle_in = '0;
    logic          busy;
    logic          ready_out;
    logic [W-1:0]  angle_out;
    logic          negate_out;

    int n_checks = 0;
    int n_fail   = 0;

    cos_range_reducer #(.WI(WI), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .angle_in   (angle_in),
        .busy       (busy),
        .ready_out  (ready_out),
        .angle_out  (angle_out),
        .negate_out (negate_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference reduction: plain modulo arithmetic on the magnitude.
    function automatic void reduce(input logic [31:0] a, output longint ang,
                                   output bit neg, output int k);
        longint v;
        longint m;
        longint r1;
        v = longint'($signed(a));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        m  = v % TWO_PI_M;
        r1 = (m >= PI_M) ? TWO_PI_M - m : m;
        if (r1 > PI_2_M) begin
            neg = 1'b1;
            ang = PI_M - r1;
            if (ang < 0) ang = 0;
        end else begin
            neg = 1'b0;
            ang = r1;
        end
`ifdef COARSE_REDUCE_EN
        k = int'(v / X8_M + (v % X8_M) / TWO_PI_M);
`else
        k = int'(v / TWO_PI_M);
`endif
    endfunction

    // Behavioural model state.
    int     cyc    = 0;
    bit     m_busy = 1'b0;
    bit     m_rdy  = 1'b0;
    longint m_ang  = 0;
    bit     m_neg  = 1'b0;
    int     m_done = 0;
    longint p_ang  = 0;
    bit     p_neg  = 1'b0;

    always @(posedge clock or negedge reset) begin
        int k;
        if (!reset) begin
            m_busy = 1'b0;
            m_rdy  = 1'b0;
            m_ang  = 0;
            m_neg  = 1'b0;
        end else begin
            cyc++;
            m_rdy = 1'b0;
            if (m_busy) begin
                if (cyc == m_done) begin
                    m_busy = 1'b0;
                    m_rdy  = 1'b1;
                    m_ang  = p_ang;
                    m_neg  = p_neg;
                end
            end else if (start) begin
                reduce(angle_in, p_ang, p_neg, k);
                m_busy = 1'b1;
                m_done = cyc + 2 + k;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        check("busy", busy, m_busy);
        check("ready_out", ready_out, m_rdy);
        check("angle_out", angle_out, m_ang);
        check("negate_out", negate_out, m_neg);
    end

    // Directed transaction with literal expectations (inputs change 1 time
    // unit after the rising edge).
    task automatic run_one(input string name, input logic [31:0] a,
                           input longint exp_ang, input bit exp_neg, input int exp_lat);
        int lat  = 0;
        bit seen = 1'b0;
        angle_in = a;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 1; i <= 80 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (ready_out) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({name, " ready seen"}, seen, 1);
        if (seen) begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " angle"}, angle_out, exp_ang);
            check({name, " negate"}, negate_out, exp_neg);
        end
        $display("txn %s: angle_in=%0d angle_out=%0d negate=%0d latency=%0d",
                 name, $signed(a), angle_out, negate_out, lat);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pick_angle();
        longint v;
        case ($urandom_range(0, 5))
            0: v = longint'($signed($urandom()));
            1: v = longint'($urandom_range(0, 32'd105414358)) - TWO_PI_M;
            2, 3: begin
                case ($urandom_range(0, 13))
                    0:  v = 0;
                    1:  v = PI_2_M;
                    2:  v = PI_2_M + 1;
                    3:  v = PI_2_M - 1;
                    4:  v = PI_M;
                    5:  v = PI_M - 1;
                    6:  v = PI_M + 1;
                    7:  v = TWO_PI_M;
                    8:  v = TWO_PI_M - 1;
                    9:  v = TWO_PI_M + 1;
                    10: v = 64'sd2147483647;
                    11: v = -64'sd2147483648;
                    12: v = X8_M;
                    default: v = X8_M - 1;
                endcase
                if ($urandom_range(0, 1) == 1 && v > 0) v = -v;
            end
            4: v = longint'($urandom_range(0, 40)) * TWO_PI_M
                   + longint'($urandom_range(0, 4)) - 2;
            default: v = longint'($urandom_range(0, 32'd421657432)) - 2 * TWO_PI_M * 2;
        endcase
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        if (v < -64'sd2147483648) v = -64'sd2147483648;
        return v[31:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        // Reset held with start pulses active.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1 start = (i % 2 == 0);
            angle_in = 32'd838860;
        end
        start = 1'b0;
        check("reset busy", busy, 0);
        check("reset angle_out", angle_out, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed results.
        run_one("0.1rad", 32'd838860, 838860, 0, 2);
        run_one("-0.1rad", -32'sd838860, 838860, 0, 2);
        run_one("2.0rad", 32'd16777216, 9576373, 1, 2);
        run_one("4.0rad", 32'd33554432, 7200842, 1, 2);
        run_one("7.0rad", 32'd58720256, 6013077, 0, 3);
        run_one("max", 32'h7FFF_FFFF, 12842897, 1, LAT_MAX);
        run_one("min", 32'h8000_0000, 12842897, 1, LAT_MAX);
        run_one("PI", 32'd26353589, 0, 1, 2);
        run_one("PI_2", 32'd13176795, 13176795, 0, 2);
        run_one("PI_2+1", 32'd13176796, 13176793, 1, 2);

        // Sweep 0..PI_2: identity mapping, no negation.
        for (int s = 0; s * 838860 <= 13176795; s++) begin
            run_one("sweep", 32'(s * 838860), longint'(s) * 838860, 0, 2);
        end

        // Start while busy and start on the completing edge are both ignored.
        angle_in = 32'd58720256;
        start    = 1'b1;
        @(posedge clock);            // accepted, k = 1 -> ready at +3
        #1 angle_in = 32'd16777216;  // start still high: sampled while busy
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 start = 1'b1;             // sampled on the edge that raises ready_out
        @(posedge clock);
        #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready_out) cnt++;
            @(posedge clock);
            #1;
        end
        check("ignored starts ready count", cnt, 1);
        check("ignored starts angle", angle_out, 6013077);
        $display("txn ignored-starts: ready pulses=%0d angle_out=%0d", cnt, angle_out);

        // Reset mid-WRAP: the abandoned operation never completes.
        angle_in = 32'h7FFF_FFFF;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1 check("mid-wrap reset busy", busy, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (ready_out) cnt++;
        end
        check("mid-wrap reset ready count", cnt, 0);
        $display("txn mid-wrap-reset: ready pulses=%0d", cnt);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            angle_in = pick_angle();
            if ($urandom_range(0, 499) == 0) reset = 1'b0;
            @(posedge clock);
            #1 reset = 1'b1;
            if (ready_out)
                $display("txn random: angle_out=%0d negate=%0d", angle_out, negate_out);
        end
        start = 1'b0;
        repeat (60) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
